// File: rtl/tmds_pkg.sv
// -----------------------------------------------------------------------------
// tmds_pkg
// Shared constants and types for the TMDS output path.
//   SYM_W             : TMDS symbol width (always 10)
//   CTRL_00..CTRL_11  : the four DC-neutral TMDS control symbols
//   IDLE_SYM_DEFAULT  : symbol sent when nothing else is available
//   LAST_BIT          : bit counter value of the final bit in a symbol
//   load_src_e        : where the serializer shift register is refilled from
// -----------------------------------------------------------------------------
package tmds_pkg;

  localparam int SYM_W = 10;

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  localparam logic [9:0] IDLE_SYM_DEFAULT = CTRL_00;

  localparam logic [3:0] LAST_BIT = 4'd9;

  // Source of the next shift register contents on a given edge.
  typedef enum logic [1:0] {
    SRC_SHIFT  = 2'd0,  // mid-word: keep shifting toward the LSB
    SRC_BUF    = 2'd1,  // word boundary: drain the holding buffer
    SRC_BYPASS = 2'd2,  // word boundary: buffer empty, take i_sym_in directly
    SRC_IDLE   = 2'd3   // word boundary: nothing available, send the idle code
  } load_src_e;

endpackage

// File: rtl/tmds_serializer.sv
// -----------------------------------------------------------------------------
// tmds_serializer
// 10:1 TMDS serializer on the bit-rate clock. Symbols from the encoder are
// accepted through a valid/ready handshake into a one-entry holding buffer
// and shifted out LSB first, one bit per clock. At each word boundary the
// shift register is refilled from the buffer, else straight from the input,
// else with the idle control symbol (which is counted as an underflow).
//
// Ports
//   i_clk           : bit-rate clock, rising edge
//   i_rst_n         : asynchronous active-low reset
//   i_sym_in        : encoded TMDS symbol
//   i_sym_valid     : i_sym_in is valid
//   o_sym_ready     : symbol is accepted on this edge if i_sym_valid is high
//   o_sdata         : serial bit (shift register LSB)
//   o_word_start    : high while o_sdata carries bit 0 of a symbol
//   o_underflow     : one-cycle pulse when the idle symbol was substituted
//   o_underflow_cnt : saturating count of idle substitutions
// -----------------------------------------------------------------------------
module tmds_serializer #(
  parameter int               SYM_W    = tmds_pkg::SYM_W,  // only 10 is supported
  parameter logic [SYM_W-1:0] IDLE_SYM = tmds_pkg::IDLE_SYM_DEFAULT,
  parameter int               UF_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [SYM_W-1:0] i_sym_in,
  input  logic             i_sym_valid,
  output logic             o_sym_ready,
  output logic             o_sdata,
  output logic             o_word_start,
  output logic             o_underflow,
  output logic [UF_W-1:0]  o_underflow_cnt
);

  import tmds_pkg::*;

  // Registered state
  logic [SYM_W-1:0] r_shift;
  logic [3:0]       r_bit_cnt;
  logic [SYM_W-1:0] r_buf;
  logic             r_buf_full;
  logic             r_underflow;
  logic [UF_W-1:0]  r_uf_cnt;

  // Combinational control and next-state values
  logic             w_load;
  logic             w_sym_ready;
  logic             w_accept;
  logic             w_buf_wr;
  logic             w_uf_sat;
  load_src_e        w_src;
  logic [SYM_W-1:0] w_shift_nxt;
  logic [3:0]       w_bit_cnt_nxt;
  logic [SYM_W-1:0] w_buf_nxt;
  logic             w_buf_full_nxt;
  logic             w_underflow_nxt;
  logic [UF_W-1:0]  w_uf_cnt_nxt;

  // The edge that ends the last bit of a word refills the shift register.
  assign w_load = (r_bit_cnt == LAST_BIT);

  // Ready depends only on registers: the buffer has room now, or it is
  // being drained into the shift register on this very edge.
  assign w_sym_ready = !r_buf_full || w_load;
  assign w_accept    = i_sym_valid && w_sym_ready;
  assign w_uf_sat    = &r_uf_cnt;

  // Choose the shift register source, buffer first so ordering is preserved.
  always_comb begin
    if (!w_load) begin
      w_src = SRC_SHIFT;
    end else if (r_buf_full) begin
      w_src = SRC_BUF;
    end else if (i_sym_valid) begin
      w_src = SRC_BYPASS;
    end else begin
      w_src = SRC_IDLE;
    end
  end

  // A bypassed symbol goes straight into the shift register, never the buffer.
  assign w_buf_wr = w_accept && (w_src != SRC_BYPASS);

  // Next shift register, bit counter and underflow bookkeeping.
  always_comb begin
    w_shift_nxt     = {1'b0, r_shift[SYM_W-1:1]};
    w_bit_cnt_nxt   = r_bit_cnt + 4'd1;
    w_underflow_nxt = 1'b0;
    w_uf_cnt_nxt    = r_uf_cnt;
    case (w_src)
      SRC_SHIFT: begin
        w_shift_nxt   = {1'b0, r_shift[SYM_W-1:1]};
        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
      end
      SRC_BUF: begin
        w_shift_nxt   = r_buf;
        w_bit_cnt_nxt = 4'd0;
      end
      SRC_BYPASS: begin
        w_shift_nxt   = i_sym_in;
        w_bit_cnt_nxt = 4'd0;
      end
      SRC_IDLE: begin
        w_shift_nxt     = IDLE_SYM;
        w_bit_cnt_nxt   = 4'd0;
        w_underflow_nxt = 1'b1;
        // Counter sticks at all-ones instead of wrapping.
        if (w_uf_sat) begin
          w_uf_cnt_nxt = r_uf_cnt;
        end else begin
          w_uf_cnt_nxt = r_uf_cnt + {{(UF_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        w_shift_nxt     = IDLE_SYM;
        w_bit_cnt_nxt   = 4'd0;
        w_underflow_nxt = 1'b0;
        w_uf_cnt_nxt    = r_uf_cnt;
      end
    endcase
  end

  // Holding buffer: a write on a draining edge refills it (old contents have
  // just moved to the shift register), otherwise a drain empties it.
  always_comb begin
    w_buf_nxt      = r_buf;
    w_buf_full_nxt = r_buf_full;
    if (w_buf_wr) begin
      w_buf_nxt      = i_sym_in;
      w_buf_full_nxt = 1'b1;
    end else if (w_src == SRC_BUF) begin
      w_buf_nxt      = r_buf;
      w_buf_full_nxt = 1'b0;
    end else begin
      w_buf_nxt      = r_buf;
      w_buf_full_nxt = r_buf_full;
    end
  end

  // State registers; reset starts an idle word with an empty buffer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift     <= IDLE_SYM;
      r_bit_cnt   <= 4'd0;
      r_buf       <= {SYM_W{1'b0}};
      r_buf_full  <= 1'b0;
      r_underflow <= 1'b0;
      r_uf_cnt    <= {UF_W{1'b0}};
    end else begin
      r_shift     <= w_shift_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_buf       <= w_buf_nxt;
      r_buf_full  <= w_buf_full_nxt;
      r_underflow <= w_underflow_nxt;
      r_uf_cnt    <= w_uf_cnt_nxt;
    end
  end

  assign o_sym_ready     = w_sym_ready;
  assign o_sdata         = r_shift[0];
  assign o_word_start    = (r_bit_cnt == 4'd0);
  assign o_underflow     = r_underflow;
  assign o_underflow_cnt = r_uf_cnt;

endmodule

// File: tb/tb_tmds_serializer.sv
// -----------------------------------------------------------------------------
// tb_tmds_serializer
// Directed bench for tmds_serializer. A table of symbols with their
// hand-written LSB-first bit order drives the stream and bypass checks;
// hand-written sequences cover reset, underflow, back-pressure, counter
// saturation (second instance with a 2-bit counter) and mid-word reset.
// Outputs are sampled 1 ns after the rising edge; inputs change there too.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tmds_serializer;

  typedef enum int {M_NONE, M_Q, M_INC, M_AT9} src_mode_e;

  typedef struct {
    logic [9:0] sym;    // symbol offered to the DUT
    logic [0:9] order;  // order[i] = i-th bit expected on sdata
  } vec_t;

  localparam int NV = 8;

  logic        clk;
  logic        rst_n;
  logic [9:0]  sym_in;
  logic        sym_valid;
  logic        sym_ready;
  logic        sdata;
  logic        word_start;
  logic        underflow;
  logic [15:0] underflow_cnt;

  logic        sat_ready;
  logic        sat_sdata;
  logic        sat_ws;
  logic        sat_uf;
  logic [1:0]  sat_cnt;

  int          checks;
  int          failures;
  vec_t        tbl [NV];
  src_mode_e   src_mode;
  logic [9:0]  src_data;
  logic [9:0]  src_q [$];
  logic [0:9]  sent, ws, uf, rdy, exp_sent, exp_uf;
  int          acc;

  tmds_serializer dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_sym_in        (sym_in),
    .i_sym_valid     (sym_valid),
    .o_sym_ready     (sym_ready),
    .o_sdata         (sdata),
    .o_word_start    (word_start),
    .o_underflow     (underflow),
    .o_underflow_cnt (underflow_cnt)
  );

  // Always starved, with a tiny counter to reach saturation quickly.
  tmds_serializer #(.UF_W(2)) dut_sat (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_sym_in        (10'd0),
    .i_sym_valid     (1'b0),
    .o_sym_ready     (sat_ready),
    .o_sdata         (sat_sdata),
    .o_word_start    (sat_ws),
    .o_underflow     (sat_uf),
    .o_underflow_cnt (sat_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [0:9] to_order(input logic [9:0] v);
    logic [0:9] r;
    for (int i = 0; i < 10; i++) r[i] = v[i];
    return r;
  endfunction

  task automatic drive_src(input int cyc);
    case (src_mode)
      M_Q: begin
        sym_valid = (src_q.size() > 0);
        sym_in    = (src_q.size() > 0) ? src_q[0] : 10'd0;
      end
      M_INC: begin
        sym_valid = 1'b1;
        sym_in    = src_data;
      end
      M_AT9: begin
        sym_valid = (cyc == 9);
        sym_in    = src_data;
      end
      default: begin
        sym_valid = 1'b0;
        sym_in    = 10'd0;
      end
    endcase
  endtask

  // Run one 10-clock word, recording per-cycle outputs and accepts.
  task automatic collect_word(output logic [0:9] o_sent, output logic [0:9] o_ws,
                              output logic [0:9] o_uf, output logic [0:9] o_rdy,
                              output int o_acc);
    logic took;
    o_acc = 0;
    for (int i = 0; i < 10; i++) begin
      drive_src(i);
      o_sent[i] = sdata;
      o_ws[i]   = word_start;
      o_uf[i]   = underflow;
      o_rdy[i]  = sym_ready;
      took      = sym_valid && sym_ready;
      tick();
      if (took) begin
        o_acc++;
        if (src_mode == M_Q) void'(src_q.pop_front());
        else src_data = src_data + 10'd1;
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    tbl[0] = '{sym: 10'b1101010100, order: 10'b0010101011};  // CTRL_00 / idle
    tbl[1] = '{sym: 10'b0010101011, order: 10'b1101010100};  // CTRL_01
    tbl[2] = '{sym: 10'b0101010100, order: 10'b0010101010};  // CTRL_10
    tbl[3] = '{sym: 10'b1010101011, order: 10'b1101010101};  // CTRL_11
    tbl[4] = '{sym: 10'h1F0,        order: 10'b0000111110};
    tbl[5] = '{sym: 10'h2AA,        order: 10'b0101010101};
    tbl[6] = '{sym: 10'h001,        order: 10'b1000000000};
    tbl[7] = '{sym: 10'h200,        order: 10'b0000000001};

    rst_n     = 1'b0;
    sym_valid = 1'b0;
    sym_in    = 10'd0;
    src_mode  = M_NONE;
    src_data  = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    check("reset sdata", 32'(sdata), 32'd0);
    check("reset word_start", 32'(word_start), 32'd1);
    check("reset sym_ready", 32'(sym_ready), 32'd1);
    check("reset underflow", 32'(underflow), 32'd0);
    check("reset underflow_cnt", 32'(underflow_cnt), 32'd0);

    // Stream: 1F0 enters the buffer at once, 2AA waits for the first load edge
    src_q.push_back(10'h1F0);
    src_q.push_back(10'h2AA);
    src_mode = M_Q;
    collect_word(sent, ws, uf, rdy, acc);
    check("w0 idle bits", 32'(sent), 32'(tbl[0].order));
    check("w0 word_start", 32'(ws), 32'(10'b1000000000));
    check("w0 ready", 32'(rdy), 32'(10'b1000000001));
    check("w0 accepts", 32'(acc), 32'd2);
    check("w0 underflow", 32'(uf), 32'd0);
    collect_word(sent, ws, uf, rdy, acc);
    check("w1 1F0 bits", 32'(sent), 32'(tbl[4].order));
    check("w1 word_start", 32'(ws), 32'(10'b1000000000));
    check("w1 ready", 32'(rdy), 32'(10'b0000000001));
    check("w1 underflow", 32'(uf), 32'd0);
    collect_word(sent, ws, uf, rdy, acc);
    check("w2 2AA bits", 32'(sent), 32'(tbl[5].order));
    check("w2 word_start", 32'(ws), 32'(10'b1000000000));
    check("w2 ready", 32'(rdy), 32'(10'b1111111111));
    check("w2 underflow", 32'(uf), 32'd0);

    // Underflow: five starved words, each starting with a one-cycle pulse
    src_mode = M_NONE;
    for (int k = 0; k < 5; k++) begin
      collect_word(sent, ws, uf, rdy, acc);
      check($sformatf("uf[%0d] idle bits", k), 32'(sent), 32'(tbl[0].order));
      check($sformatf("uf[%0d] pulse", k), 32'(uf), 32'(10'b1000000000));
      check($sformatf("uf[%0d] word_start", k), 32'(ws), 32'(10'b1000000000));
    end
    // Loads ending words 2..7 were all starved
    check("underflow_cnt after starve", 32'(underflow_cnt), 32'd6);
    // Second instance starved on all 8 loads so far: 2-bit counter pinned at 3
    check("sat cnt", 32'(sat_cnt), 32'd3);
    check("sat pulse still fires", 32'(sat_uf), 32'd1);

    // Back-pressure: valid held high, data increments on each accept
    src_mode = M_INC;
    src_data = 10'h100;
    collect_word(sent, ws, uf, rdy, acc);
    check("bp0 idle bits", 32'(sent), 32'(tbl[0].order));
    check("bp0 pulse", 32'(uf), 32'(10'b1000000000));
    check("bp0 accepts", 32'(acc), 32'd2);
    check("bp0 ready", 32'(rdy), 32'(10'b1000000001));
    for (int k = 0; k < 20; k++) begin
      collect_word(sent, ws, uf, rdy, acc);
      check($sformatf("bp[%0d] bits", k), 32'(sent), 32'(to_order(10'h100 + 10'(k))));
      check($sformatf("bp[%0d] accepts", k), 32'(acc), 32'd1);
      check($sformatf("bp[%0d] ready", k), 32'(rdy), 32'(10'b0000000001));
      check($sformatf("bp[%0d] underflow", k), 32'(uf), 32'd0);
      check($sformatf("bp[%0d] word_start", k), 32'(ws), 32'(10'b1000000000));
    end
    check("underflow_cnt after bp", 32'(underflow_cnt), 32'd6);

    // Mid-word reset: 114 is being sent, 115 sits in the buffer
    src_mode = M_NONE;
    for (int i = 0; i < 4; i++) begin
      drive_src(i);
      tick();
    end
    check("pre-reset sdata (114 bit4)", 32'(sdata), 32'd1);
    check("pre-reset ready (buf full)", 32'(sym_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("async reset sdata", 32'(sdata), 32'd0);
    check("async reset word_start", 32'(word_start), 32'd1);
    check("async reset ready", 32'(sym_ready), 32'd1);
    check("async reset underflow", 32'(underflow), 32'd0);
    check("async reset underflow_cnt", 32'(underflow_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    collect_word(sent, ws, uf, rdy, acc);
    check("rst w0 idle bits", 32'(sent), 32'(tbl[0].order));
    check("rst w0 underflow", 32'(uf), 32'd0);
    check("rst w0 ready (buf discarded)", 32'(rdy), 32'(10'b1111111111));
    collect_word(sent, ws, uf, rdy, acc);
    check("rst w1 idle bits", 32'(sent), 32'(tbl[0].order));
    check("rst w1 pulse", 32'(uf), 32'(10'b1000000000));
    check("rst underflow_cnt", 32'(underflow_cnt), 32'd2);

    // Bypass: each symbol offered only in the last bit slot of a word
    for (int k = 0; k <= NV; k++) begin
      if (k < NV) begin
        src_mode = M_AT9;
        src_data = tbl[k].sym;
      end else begin
        src_mode = M_NONE;
      end
      collect_word(sent, ws, uf, rdy, acc);
      exp_sent = (k == 0) ? tbl[0].order : tbl[(k == 0) ? 0 : k - 1].order;
      exp_uf   = (k == 0) ? 10'b1000000000 : 10'b0000000000;
      check($sformatf("byp[%0d] bits", k), 32'(sent), 32'(exp_sent));
      check($sformatf("byp[%0d] underflow", k), 32'(uf), 32'(exp_uf));
      check($sformatf("byp[%0d] ready (buf empty)", k), 32'(rdy), 32'(10'b1111111111));
    end
    check("underflow_cnt after bypass", 32'(underflow_cnt), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tmds_serializer.md
# tmds_serializer

Single-clock 10:1 TMDS serializer that consumes the 10-bit symbols produced by the DC-balancing encoder stage and shifts them out one bit per clock, LSB first. It sits between the per-channel encoder and the output pad/ODDR, running on the bit-rate clock (10× pixel clock). A one-entry holding buffer with a valid/ready handshake decouples the encoder from the bit timing. When no symbol is ready, it substitutes a DC-neutral control symbol and counts the underflow.

## Interface
- SYM_W, 10, symbol width; fixed by TMDS, and only the value 10 is supported.
- IDLE_SYM, 10'b1101010100, symbol sent on underflow and after reset (control code C1C0=00).
- UF_W, 16, width of the saturating underflow counter.

- clk  in  1  bit-rate clock; all state is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sym_in  in  SYM_W  encoded TMDS symbol from the encoder stage.
- sym_valid  in  1  sym_in is valid.
- sym_ready  out  1  block accepts sym_in on this edge when sym_valid is also high.
- sdata  out  1  serial bit, registered, driven from shift[0].
- word_start  out  1  high while sdata carries bit 0 of a symbol.
- underflow  out  1  one-cycle pulse when IDLE_SYM is loaded because no symbol was available.
- underflow_cnt  out  UF_W  saturating count of underflow loads.

## Operation
- State:
  - shift[9:0], a shift register.
  - bit_cnt[3:0], counting 0..9.
  - buf[9:0] with a buf_full flag.
  - underflow_cnt, underflow.
- Reset values:
  - shift=IDLE_SYM, so sdata=0.
  - bit_cnt=0, so word_start=1.
  - buf_full=0, so sym_ready=1.
  - underflow=0, underflow_cnt=0.
- A load edge is any edge where bit_cnt==9 before the edge.
- Non-load edge:
  - shift <= {1'b0, shift[9:1]}.
  - bit_cnt increments.
- Load edge:
  - bit_cnt <= 0.
  - shift is loaded, by priority:
    1. buf, if buf_full; buf_full then clears unless refilled on the same edge.
    2. Otherwise sym_in, if sym_valid (bypass); buf stays empty.
    3. Otherwise IDLE_SYM; underflow <= 1 and underflow_cnt increments, saturating at all-ones.
- underflow is 0 on every edge that is not an underflow load.
- sym_ready = !buf_full || (bit_cnt==9). This is combinational from registers only and never depends on sym_valid.
- Accept (sym_valid && sym_ready) without a bypass: buf <= sym_in, buf_full <= 1.
- Simultaneous accept and drain on a load edge with buf_full: shift takes the old buf and buf takes sym_in.
- sym_in is ignored whenever sym_ready is 0.
- word_start = (bit_cnt==0).

## Timing
- Word period is exactly 10 clocks. Load edges occur on the 10th, 20th, … rising edge after rst_n deasserts.
- The first word after reset is always IDLE_SYM.
- Latency:
  - Bypass on a load edge: bit 0 of the accepted symbol appears on sdata in the cycle right after that edge.
  - Buffered symbol: transmitted starting after the next load edge, a latency of 1–10 clocks.
- Steady-state back-pressure (continuous sym_valid): exactly one accept per 10 clocks, and sym_ready is high only when bit_cnt==9.
- Asynchronous rst_n assertion mid-word:
  - All outputs go immediately to their reset values.
  - Any buffered symbol is discarded.
- underflow_cnt is cleared only by reset.

## Structure
- Shared package tmds_pkg holds:
  - SYM_W.
  - The four TMDS control symbols CTRL_00 (10'b1101010100), CTRL_01 (10'b0010101011), CTRL_10 (10'b0101010100), CTRL_11 (10'b1010101011).
  - The default for IDLE_SYM, which is CTRL_00.
- The block has no sub-modules; it is one module of roughly 150 RTL lines.

## Test plan
- Reset:
  - Hold rst_n=0 for 3 clocks, then release.
  - Required: sdata=0, word_start=1, sym_ready=1, underflow_cnt=0.
  - Required: the first 10 bits are 0,0,1,0,1,0,1,0,1,1 (IDLE_SYM LSB first).
- Stream:
  - Offer 10'h1F0 then 10'h2AA back-to-back.
  - Required: sdata gives 0,0,0,0,1,1,1,1,1,0 then 0,1,0,1,0,1,0,1,0,1.
  - Required: word_start pulses every 10 clocks and underflow stays 0.
- Underflow:
  - Keep sym_valid=0 for 5 words after the first.
  - Required: IDLE_SYM repeats, there are 5 one-cycle underflow pulses spaced 10 clocks apart, and underflow_cnt reaches 5 (6 counting the first load edge).
  - Force the count to 16'hFFFF. Required: it stays at FFFF on the next underflow.
- Back-pressure:
  - Hold sym_valid=1 with data incrementing on each accept, for 20 words.
  - Required: the accept count is 1 per 10 clocks, sym_ready is high only at bit_cnt==9, and the words come out in order with no gaps.
- Bypass:
  - With the buffer empty, assert sym_valid for one cycle exactly when bit_cnt==9.
  - Required: that symbol is sent in the next word, underflow=0, and buf_full stays 0.
- Mid-word reset:
  - Pulse rst_n low at bit_cnt=4 while buf_full=1.
  - Required: sdata is 0 immediately.
  - Required: after release, the IDLE_SYM word is sent and then an underflow occurs, because the buffer was discarded.
